// File: rtl/im_cache_pool_reader.sv
// -----------------------------------------------------------------------------
// im_cache_pool_reader
//
// Reads back the four-way image cache after a conv filter's write pass and
// emits the 2x2 max-pooled image in raster order.
//
// The four sub-caches hold the four phases of the conv output:
//   slice 0 = even row / even col, slice 1 = even row / odd col,
//   slice 2 = odd row / even col,  slice 3 = odd row / odd col.
// All four share one read address, so each read returns one complete 2x2
// neighbourhood. The fp16 maximum of that neighbourhood is one output pixel.
// Reading the pooled grid in raster order (prow*PC + pcol) gives the
// addresses 0, 1, 2, ... PR*PC-1, so a plain incrementing address counter
// is enough.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   max_row_in/max_col_in conv output rows R / cols C (>= 1)
//   params_valid_in      latch R and C (honoured in IDLE only)
//   start_in             begin a pooling pass (honoured in IDLE only)
//   cache_rd_addr_out    shared read address for the four sub-caches
//   cache_rd_en_out      read strobe
//   cache_data_in        {slice3, slice2, slice1, slice0}, IM_CACHE_DELAY
//                        cycles after the read strobe
//   pixel_out            pooled pixel (head of the output FIFO)
//   pixel_valid_out      output FIFO non-empty
//   pixel_ready_in       downstream ready
//   busy_out             pass in progress
//   done_out             one-cycle pulse with the final pixel's handshake
//
// Optional feature macro: IM_POOL_RELU_EN
//   When defined, a pooled result with its sign bit set (negative values,
//   -0 and -inf) is replaced by +0 before it enters the output FIFO.
// -----------------------------------------------------------------------------
module im_cache_pool_reader #(
    parameter int DATA_WIDTH     = 16,
    parameter int DIM_WIDTH      = 9,
    parameter int IM_CACHE_DEPTH = 1024,
    parameter int IM_CACHE_DELAY = 2,
    parameter int OUT_FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DIM_WIDTH-1:0]              max_row_in,
    input  logic [DIM_WIDTH-1:0]              max_col_in,
    input  logic                              params_valid_in,
    input  logic                              start_in,
    output logic [$clog2(IM_CACHE_DEPTH)-1:0] cache_rd_addr_out,
    output logic                              cache_rd_en_out,
    input  logic [4*DATA_WIDTH-1:0]           cache_data_in,
    output logic [DATA_WIDTH-1:0]             pixel_out,
    output logic                              pixel_valid_out,
    input  logic                              pixel_ready_in,
    output logic                              busy_out,
    output logic                              done_out
);

    localparam int ADDR_WIDTH = $clog2(IM_CACHE_DEPTH);
    localparam int CNT_WIDTH  = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int PTR_WIDTH  = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;

    localparam logic [DIM_WIDTH-1:0]  DIM_ONE   = DIM_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0]  PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0]  PTR_LAST  = PTR_WIDTH'(OUT_FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH:0]    DEPTH_EXT = (CNT_WIDTH + 1)'(OUT_FIFO_DEPTH);
    // fp16 -infinity: used to neutralise neighbourhood slots outside the image.
    localparam logic [DATA_WIDTH-1:0] NEG_INF   = DATA_WIDTH'(16'hFC00);
    localparam logic [DATA_WIDTH-1:0] SIGN_BIT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // fp16 ordering: mapping negatives to their complement and setting the top
    // bit of positives yields keys whose unsigned order is the numeric order,
    // with +0 above -0.
    // -------------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] fp_key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x | SIGN_BIT);
    endfunction

    // Ties keep the first argument, which is always the lower slice index.
    function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        return (fp_key(b) > fp_key(a)) ? b : a;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  state_reg;
    logic [DIM_WIDTH-1:0]    r_reg, c_reg;
    logic [DIM_WIDTH-1:0]    pr_reg, pc_reg;
    logic [DIM_WIDTH-1:0]    prow_reg, pcol_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    busy_reg;

    logic [CNT_WIDTH-1:0]    in_flight_reg;
    logic [CNT_WIDTH-1:0]    fifo_count_reg;
    logic [PTR_WIDTH-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [DATA_WIDTH-1:0]   fifo_mem [OUT_FIFO_DEPTH];

    logic [IM_CACHE_DELAY-1:0] dly_valid_reg;
    logic [IM_CACHE_DELAY-1:0] dly_mask_c_reg;
    logic [IM_CACHE_DELAY-1:0] dly_mask_r_reg;

    logic                    a_valid_reg;
    logic [DATA_WIDTH-1:0]   a_lo_reg, a_hi_reg;
    logic                    b_valid_reg;
    logic [DATA_WIDTH-1:0]   b_data_reg;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH:0]      credit_used;
    logic                    credit_ok;
    logic                    rd_issue;
    logic                    last_col, last_row;
    logic                    issue_mask_c, issue_mask_r;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic                    final_pop;

    // A read is only launched if its result is guaranteed a FIFO slot, so the
    // pipeline never needs to stall and the FIFO never overflows.
    assign credit_used  = {1'b0, fifo_count_reg} + {1'b0, in_flight_reg};
    assign credit_ok    = credit_used < DEPTH_EXT;
    assign rd_issue     = (state_reg == READ) && credit_ok;

    assign last_col     = (pcol_reg == pc_reg - DIM_ONE);
    assign last_row     = (prow_reg == pr_reg - DIM_ONE);
    // An odd dimension leaves the final pooled column/row with a half window.
    assign issue_mask_c = c_reg[0] && last_col;
    assign issue_mask_r = r_reg[0] && last_row;

    assign fifo_empty   = (fifo_count_reg == '0);
    assign fifo_pop     = !fifo_empty && pixel_ready_in;
    // in_flight only drops when a result lands in the FIFO, so in_flight == 0
    // with a single FIFO entry popping means this is the very last pixel.
    assign final_pop    = (state_reg == DRAIN) && (in_flight_reg == '0) &&
                          (fifo_count_reg == CNT_ONE) && pixel_ready_in;

    assign cache_rd_en_out   = rd_issue;
    assign cache_rd_addr_out = addr_reg;
    assign pixel_valid_out   = !fifo_empty;
    assign pixel_out         = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign busy_out          = busy_reg;
    assign done_out          = final_pop;

    // -------------------------------------------------------------------------
    // Parameters and pass control
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pr_reg <= '0;
            pc_reg <= '0;
        end else begin
            // ceil(x/2) without needing an extra carry bit
            pr_reg <= (r_reg >> 1) + {{(DIM_WIDTH-1){1'b0}}, r_reg[0]};
            pc_reg <= (c_reg >> 1) + {{(DIM_WIDTH-1){1'b0}}, c_reg[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            r_reg     <= '0;
            c_reg     <= '0;
            prow_reg  <= '0;
            pcol_reg  <= '0;
            addr_reg  <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (params_valid_in) begin
                        r_reg <= max_row_in;
                        c_reg <= max_col_in;
                    end
                    if (start_in) begin
                        state_reg <= READ;
                        busy_reg  <= 1'b1;
                        prow_reg  <= '0;
                        pcol_reg  <= '0;
                        addr_reg  <= '0;
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr_reg <= addr_reg + ADDR_ONE;
                        if (last_col) begin
                            pcol_reg <= '0;
                            prow_reg <= prow_reg + DIM_ONE;
                            if (last_row) begin
                                state_reg <= DRAIN;
                            end
                        end else begin
                            pcol_reg <= pcol_reg + DIM_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (final_pop) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Reads whose result has not yet been written into the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_flight_reg <= '0;
        end else begin
            case ({rd_issue, b_valid_reg})
                2'b10:   in_flight_reg <= in_flight_reg + CNT_ONE;
                2'b01:   in_flight_reg <= in_flight_reg - CNT_ONE;
                default: in_flight_reg <= in_flight_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read-strobe / edge-mask delay line, aligned with cache_data_in
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dly_valid_reg  <= '0;
            dly_mask_c_reg <= '0;
            dly_mask_r_reg <= '0;
        end else begin
            dly_valid_reg[0]  <= rd_issue;
            dly_mask_c_reg[0] <= rd_issue && issue_mask_c;
            dly_mask_r_reg[0] <= rd_issue && issue_mask_r;
            for (int i = IM_CACHE_DELAY - 1; i > 0; i--) begin
                dly_valid_reg[i]  <= dly_valid_reg[i-1];
                dly_mask_c_reg[i] <= dly_mask_c_reg[i-1];
                dly_mask_r_reg[i] <= dly_mask_r_reg[i-1];
            end
        end
    end

    logic tap_valid, tap_mask_c, tap_mask_r;
    assign tap_valid  = dly_valid_reg[IM_CACHE_DELAY-1];
    assign tap_mask_c = dly_mask_c_reg[IM_CACHE_DELAY-1];
    assign tap_mask_r = dly_mask_r_reg[IM_CACHE_DELAY-1];

    // -------------------------------------------------------------------------
    // Slice extraction and edge masking. Slice index bit 0 selects the odd
    // column, bit 1 the odd row; slice 0 is always inside the image.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] slice_val [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            localparam bit ODD_COL = (gi % 2) == 1;
            localparam bit ODD_ROW = gi >= 2;
            logic drop;
            assign drop = (ODD_COL && tap_mask_c) || (ODD_ROW && tap_mask_r);
            assign slice_val[gi] = drop ? NEG_INF
                                        : cache_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stage A: pairwise max. Stage B: final max (optionally rectified).
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] b_max;
    logic [DATA_WIDTH-1:0] b_result;

    always_comb begin
        b_max    = fp_max(a_lo_reg, a_hi_reg);
        b_result = b_max;
`ifdef IM_POOL_RELU_EN
        if (b_max[DATA_WIDTH-1]) begin
            b_result = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_reg <= 1'b0;
            a_lo_reg    <= '0;
            a_hi_reg    <= '0;
            b_valid_reg <= 1'b0;
            b_data_reg  <= '0;
        end else begin
            a_valid_reg <= tap_valid;
            a_lo_reg    <= fp_max(slice_val[0], slice_val[1]);
            a_hi_reg    <= fp_max(slice_val[2], slice_val[3]);
            b_valid_reg <= a_valid_reg;
            b_data_reg  <= b_result;
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO. Credit accounting keeps it from overflowing, so a write
    // and a read may coincide at any fill level.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (b_valid_reg) begin
            fifo_mem[wr_ptr_reg] <= b_data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (b_valid_reg) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_ONE;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_ONE;
            end
            case ({b_valid_reg, fifo_pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNT_ONE;
                2'b01:   fifo_count_reg <= fifo_count_reg - CNT_ONE;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_im_cache_pool_reader.sv
// -----------------------------------------------------------------------------
// Bench for im_cache_pool_reader. A behavioural cache returns data a fixed
// number of cycles after each read; a reference model decodes fp16 to real
// numbers, forms every pooled window from the image geometry and predicts
// the pixel stream. Build with +define+IM_POOL_RELU_EN to cover the
// rectified variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_im_cache_pool_reader;

    localparam int DW    = 16;
    localparam int DIMW  = 9;
    localparam int DEPTH = 1024;
    localparam int DELAY = 2;
    localparam int FDEP  = 8;

    logic            clk;
    logic            reset;
    logic [DIMW-1:0] max_row_in, max_col_in;
    logic            params_valid_in, start_in;
    logic [9:0]      cache_rd_addr_out;
    logic            cache_rd_en_out;
    logic [4*DW-1:0] cache_data_in;
    logic [DW-1:0]   pixel_out;
    logic            pixel_valid_out, pixel_ready_in;
    logic            busy_out, done_out;

    im_cache_pool_reader #(
        .DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .IM_CACHE_DEPTH(DEPTH),
        .IM_CACHE_DELAY(DELAY), .OUT_FIFO_DEPTH(FDEP)
    ) dut (
        .clk(clk), .reset(reset),
        .max_row_in(max_row_in), .max_col_in(max_col_in),
        .params_valid_in(params_valid_in), .start_in(start_in),
        .cache_rd_addr_out(cache_rd_addr_out), .cache_rd_en_out(cache_rd_en_out),
        .cache_data_in(cache_data_in),
        .pixel_out(pixel_out), .pixel_valid_out(pixel_valid_out),
        .pixel_ready_in(pixel_ready_in),
        .busy_out(busy_out), .done_out(done_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- cache model ----------------
    logic [DW-1:0]   cmem [4][DEPTH];
    logic [4*DW-1:0] cpipe [DELAY];

    always @(posedge clk) begin
        cpipe[0] <= cache_rd_en_out ? {cmem[3][cache_rd_addr_out], cmem[2][cache_rd_addr_out],
                                       cmem[1][cache_rd_addr_out], cmem[0][cache_rd_addr_out]}
                                    : '0;
        for (int i = 1; i < DELAY; i++) cpipe[i] <= cpipe[i-1];
    end
    assign cache_data_in = cpipe[DELAY-1];

    function automatic logic [DW-1:0] rand_fp();
        logic [DW-1:0] x;
        x = DW'($urandom);
        case ($urandom_range(0, 7))
            0: x = 16'h0000;
            1: x = 16'h8000;
            2: x = 16'h3C00;
            3: x = 16'hBC00;
            default: ;
        endcase
        if (x[14:10] == 5'h1F) x[14] = 1'b0;   // keep clear of inf/NaN
        return x;
    endfunction

    task automatic fill_const(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                              input logic [DW-1:0] v2, input logic [DW-1:0] v3);
        for (int a = 0; a < DEPTH; a++) begin
            cmem[0][a] = v0; cmem[1][a] = v1; cmem[2][a] = v2; cmem[3][a] = v3;
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < 4; k++) cmem[k][a] = rand_fp();
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int n);
        real p = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
        else        for (int i = 0; i < -n; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic real fp2r(input logic [DW-1:0] x);
        int  e = int'(x[14:10]);
        int  m = int'(x[9:0]);
        real v;
        if (e == 31)     v = 1.0e300;
        else if (e == 0) v = m * pow2(-24);
        else             v = (1024 + m) * pow2(e - 25);
        return x[15] ? -v : v;
    endfunction

    // true when a is numerically larger than b; +0 counts as larger than -0
    function automatic bit beats(input logic [DW-1:0] a, input logic [DW-1:0] b);
        real ra = fp2r(a);
        real rb = fp2r(b);
        return (ra > rb) || (ra == rb && !a[15] && b[15]);
    endfunction

    logic [DW-1:0] exp_q [$];
    int exp_npix = 0;

    task automatic build_expected(input int r, input int c);
        int pr, pc, addr;
        logic [DW-1:0] cand, best;
        exp_q.delete();
        pr = (r + 1) / 2;
        pc = (c + 1) / 2;
        exp_npix = pr * pc;
        for (int y = 0; y < pr; y++) begin
            for (int x = 0; x < pc; x++) begin
                addr = y * pc + x;
                best = 16'h0;
                for (int k = 0; k < 4; k++) begin
                    // slice k covers image pixel (2y + k/2, 2x + k%2)
                    if ((2*y + k/2) < r && (2*x + k%2) < c) cand = cmem[k][addr];
                    else                                    cand = 16'hFC00;
                    if (k == 0 || beats(cand, best)) best = cand;
                end
`ifdef IM_POOL_RELU_EN
                if (best[15]) best = 16'h0000;
`endif
                exp_q.push_back(best);
            end
        end
    endtask

    // ---------------- ready driver ----------------
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 one on / three off
    initial begin
        int phase = 0;
        pixel_ready_in = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       pixel_ready_in = ($urandom_range(0, 3) != 0);
                2:       begin pixel_ready_in = (phase == 0); phase = (phase + 1) % 4; end
                default: pixel_ready_in = 1'b1;
            endcase
        end
    end

    // ---------------- monitor ----------------
    int  pix_cnt = 0, done_cnt = 0, exp_addr = 0, first_cyc = -1;
    bit  quiet = 0;
    bit  prev_stall = 0, prev_rst = 1;
    logic [DW-1:0] prev_pix = '0;
    logic [DW-1:0] mon_exp;

    always @(negedge clk) begin
        if (pixel_valid_out && first_cyc < 0) first_cyc = cyc;
        if (cache_rd_en_out) begin
            check("rd_addr", 32'(cache_rd_addr_out), 32'(exp_addr));
            exp_addr++;
            check("rd_bound", 32'(exp_addr <= exp_npix), 32'd1);
        end
        if (prev_stall && !prev_rst) begin
            check("stall_valid", 32'(pixel_valid_out), 32'd1);
            check("stall_hold", 32'(pixel_out), 32'(prev_pix));
        end
        if (pixel_valid_out && pixel_ready_in) begin
            pix_cnt++;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("pixel", 32'(pixel_out), 32'(mon_exp));
            end else begin
                check("extra_pixel", 32'd1, 32'd0);
            end
        end
        if (done_out) begin
            done_cnt++;
            check("done_handshake", 32'(pixel_valid_out && pixel_ready_in), 32'd1);
            check("done_last", 32'(exp_q.size()), 32'd0);
        end
        if (quiet) begin
            check("quiet_valid", 32'(pixel_valid_out), 32'd0);
            check("quiet_done", 32'(done_out), 32'd0);
            check("quiet_rd", 32'(cache_rd_en_out), 32'd0);
        end
        prev_stall = pixel_valid_out && !pixel_ready_in;
        prev_pix   = pixel_out;
        prev_rst   = reset;
    end

    // ---------------- stimulus tasks ----------------
    int cur_r = 0, cur_c = 0, start_cyc = 0, pix_base = 0, done_base = 0;

    task automatic load_params(input int r, input int c);
        @(posedge clk); #1;
        max_row_in = DIMW'(r); max_col_in = DIMW'(c); params_valid_in = 1'b1;
        @(posedge clk); #1;
        params_valid_in = 1'b0;
        @(posedge clk); #1;
        cur_r = r; cur_c = c;
    endtask

    task automatic start_pass();
        build_expected(cur_r, cur_c);
        exp_addr  = 0;
        first_cyc = -1;
        pix_base  = pix_cnt;
        done_base = done_cnt;
        @(posedge clk); #1;
        start_in  = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start_in  = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy_out), 32'd1);
    endtask

    task automatic wait_done(input bit measure);
        int t = 0;
        while (done_cnt == done_base && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(done_cnt != done_base), 32'd1);
        repeat (30) @(negedge clk);
        check("done_once", 32'(done_cnt - done_base), 32'd1);
        check("pix_count", 32'(pix_cnt - pix_base), 32'(exp_npix));
        check("addr_count", 32'(exp_addr), 32'(exp_npix));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("busy_idle", 32'(busy_out), 32'd0);
        if (measure) check("first_latency", 32'(first_cyc - start_cyc), 32'(DELAY + 4));
        $display("pass R=%0d C=%0d pixels=%0d ready_mode=%0d", cur_r, cur_c, pix_cnt - pix_base, rdy_mode);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(pixel_valid_out), 32'd0);
        check({tag, "_pixel"}, 32'(pixel_out), 32'd0);
        check({tag, "_rd_en"}, 32'(cache_rd_en_out), 32'd0);
        check({tag, "_rd_addr"}, 32'(cache_rd_addr_out), 32'd0);
        check({tag, "_busy"}, 32'(busy_out), 32'd0);
        check({tag, "_done"}, 32'(done_out), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        max_row_in = '0; max_col_in = '0;
        params_valid_in = 1'b0; start_in = 1'b0;
        fill_const(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // 4x4 image, slice k holds k+1.0
        fill_const(16'h3C00, 16'h4000, 16'h4200, 16'h4400);
        load_params(4, 4); start_pass(); wait_done(1'b1);

        // 3x3 image: the odd-odd 9.0 only survives in the interior window
        fill_const(16'h3C00, 16'h3C00, 16'h3C00, 16'h4880);
        load_params(3, 3); start_pass(); wait_done(1'b1);

        // all-negative neighbourhood
        fill_const(16'hC000, 16'hBC00, 16'hC200, 16'hB800);
        load_params(2, 2); start_pass(); wait_done(1'b1);

        // single pixel image
        fill_random();
        load_params(1, 1); start_pass(); wait_done(1'b1);

        // random geometry, data and backpressure
        rdy_mode = 1;
        for (int n = 0; n < 6; n++) begin
            fill_random();
            load_params($urandom_range(1, 12), $urandom_range(1, 12));
            start_pass(); wait_done(1'b0);
        end

        // heavy backpressure, 8x8
        rdy_mode = 2;
        fill_random();
        load_params(8, 8); start_pass(); wait_done(1'b0);

        // reset in the middle of a pass
        fill_random();
        load_params(8, 8); start_pass();
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        exp_q.delete();
        quiet = 1'b1;
        repeat (20) @(negedge clk);
        quiet = 1'b0;
        rdy_mode = 0;
        load_params(8, 8); start_pass(); wait_done(1'b1);

        // start and parameter strobes while busy must be ignored
        rdy_mode = 1;
        fill_random();
        load_params(6, 4); start_pass();
        repeat (3) @(posedge clk);
        #1;
        start_in = 1'b1; params_valid_in = 1'b1;
        max_row_in = DIMW'(2); max_col_in = DIMW'(2);
        @(posedge clk); #1;
        start_in = 1'b0; params_valid_in = 1'b0;
        wait_done(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/im_cache_pool_reader.md
Name: im_cache_pool_reader

Overview:
- Downstream consumer of the four-way image cache written by the conv output stage.
- Once a filter's write pass completes, it walks the cache in pooled raster order and reads all four sub-caches at the same address in parallel, which yields one 2x2 neighbourhood per read.
- It computes the fp16 maximum of each neighbourhood and streams the pooled pixels out on a valid/ready interface toward the output writer.

Parameters:
- DATA_WIDTH, 16, fp16 pixel width.
- DIM_WIDTH, 9, row/column dimension width.
- IM_CACHE_DEPTH, 1024, words per sub-cache.
- IM_CACHE_DELAY, 2, cache read latency in cycles (address to data).
- OUT_FIFO_DEPTH, 8, output skid FIFO depth; must be >= IM_CACHE_DELAY+3.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- max_row_in  in  DIM_WIDTH  conv output rows R (>=1).
- max_col_in  in  DIM_WIDTH  conv output cols C (>=1).
- params_valid_in  in  1  latch R and C.
- start_in  in  1  begin pooling pass; connected to the writer's last-write strobe.
- cache_rd_addr_out  out  clog2(IM_CACHE_DEPTH)  shared read address for all 4 sub-caches.
- cache_rd_en_out  out  1  read strobe.
- cache_data_in  in  4*DATA_WIDTH  sub-cache data; slice k belongs to sub-cache k (0=even row/even col, 1=even/odd, 2=odd/even, 3=odd/odd).
- pixel_out  out  DATA_WIDTH  pooled pixel.
- pixel_valid_out  out  1  pooled pixel valid.
- pixel_ready_in  in  1  downstream ready.
- busy_out  out  1  pass in progress.
- done_out  out  1  one-cycle pulse when the final pooled pixel is accepted.

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- Reset values: every output is 0; state goes to IDLE; FIFO, counters and in-flight count are cleared; R and C are cleared.
  - Reset mid-pass abandons the pass and discards all in-flight data.
  - Nothing is emitted after reset until a new start_in arrives.
- Parameter latching: params_valid_in latches R and C only in IDLE; it is ignored otherwise.
- Derived values:
  - PR = ceil(R/2) and PC = ceil(C/2), registered one cycle after latch.
  - Pooled pixel count = PR*PC.
- State machine:
  - IDLE: start_in -> READ. Output and out-row/out-col counters are zeroed. busy_out=1 from the next cycle.
  - READ: each cycle with credit available, assert cache_rd_en_out with addr = prow*PC + pcol.
    - Column counter increments; at PC-1 it wraps to 0 and the row counter increments.
    - After address (PR-1, PC-1) is issued -> DRAIN.
  - DRAIN: wait until in-flight=0, the FIFO is empty and the last pixel is handshaked -> IDLE.
    - done_out pulses in the cycle of that final handshake.
    - busy_out drops in the next cycle.
  - start_in outside IDLE is ignored.
- Credit rule: issue a read only if fifo_count + in_flight < OUT_FIFO_DEPTH. in_flight counts reads issued whose result has not yet been written to the FIFO. The FIFO never overflows.
- Pipeline:
  - rd_en and the edge-mask bits go through a shift register of IM_CACHE_DELAY cycles, aligned with cache_data_in.
  - Stage A: registered pairwise max, max(s0,s1) and max(s2,s3).
  - Stage B: registered final max, then written to the FIFO.
  - FIFO head drives pixel_out; pixel_valid_out = FIFO non-empty.
  - With pixel_ready_in held high and an empty FIFO, the first pixel_valid_out asserts exactly IM_CACHE_DELAY+4 cycles after the start_in cycle. Throughput is then 1 pixel/cycle.
- Handshake:
  - Transfer occurs when pixel_valid_out & pixel_ready_in.
  - pixel_out is held stable while valid and not ready.
  - A FIFO write and read in the same cycle are allowed at any fill level, including full and empty.
- Edge masking:
  - If C is odd and pcol=PC-1, slices 1 and 3 are replaced by 0xFC00 (-inf).
  - If R is odd and prow=PR-1, slices 2 and 3 are replaced by 0xFC00.
  - Slice 0 is never masked.
- fp16 compare:
  - Map each value to key = sign ? ~x : x|0x8000, then compare keys unsigned.
  - A tie selects the lower slice index.
  - +0 > -0.
  - NaN is not special-cased.
- R=1, C=1 produces exactly one pixel equal to slice 0.

Optional Feature:
- Macro: IM_POOL_RELU_EN.
- When defined: the Stage B result is forced to 0x0000 if its sign bit is 1 (this includes -0 and -inf). Latency is unchanged.
- When undefined: the raw maximum passes through, negative values included.

Test Plan:
- R=4, C=4, sub-cache k holds value k+1.0 at every address -> 4 outputs of 0x4400 (4.0); addresses 0,1,2,3 are issued once each; done_out pulses exactly once.
- R=3, C=3, slice 3 holds 9.0 (0x4880), slices 0..2 hold 1.0 -> outputs in order 9.0, 1.0, 1.0, 1.0, because the masked corners drop the 9.0 for the last column, last row and corner pixel.
- All slices negative (-2.0 = 0xC000, -1.0 = 0xBC00, -3.0 = 0xC200, -0.5 = 0xB800) -> 0xB800 without IM_POOL_RELU_EN and 0x0000 with it.
- R=8, C=8 with pixel_ready_in toggling 1 cycle on, 3 off -> 16 outputs in raster order with none lost or duplicated, fifo_count never exceeds OUT_FIFO_DEPTH, and pixel_out stays stable while stalled.
- Assert reset for one cycle midway through the R=8, C=8 pass -> next cycle all outputs are 0; no pixel_valid_out or done_out follows until a new start_in, after which a full 16-pixel pass completes.
- start_in pulsed again while busy_out=1 -> ignored; exactly one pass and one done_out result.
